bus_demux_reg: RTL and testbench

BUS_DEMUX_REG -- requirements
Module: bus_demux_reg

---
 rtl/sap_bus_pkg.sv | 22 ++
 rtl/demux_chan_reg.sv | 46 ++++
 rtl/bus_demux_reg.sv | 78 +++++++
 tb/tb_bus_demux_reg.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_bus_pkg.sv
// Shared constants and types for the registered bus demultiplexer.
// Holds default sizing, the select-width helper and channel state encoding.
package sap_bus_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int NCH_DEF   = 8;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } chan_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One demux output channel: a single-entry holding register.
// Refill is allowed in the same cycle the sink drains the entry.
module demux_chan_reg
    import sap_bus_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             writable_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    chan_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (wr_i) begin
            state_d = CH_FULL;
            data_d  = data_i;
        end else if (pop_i) begin
            state_d = CH_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= CH_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign writable_o = (state_q == CH_EMPTY) | pop_i;
    assign valid_o    = (state_q == CH_FULL);
    assign data_o     = data_q;

endmodule

// File: rtl/bus_demux_reg.sv
// Registered 1-to-NCH bus demultiplexer with broadcast and a sticky
// error flag for words addressed to a channel that does not exist.
module bus_demux_reg
    import sap_bus_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int NCH   = NCH_DEF,
    localparam int SELW  = clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SELW-1:0]      sel,
    input  logic                 bcast,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic                 err_sel
);

    logic [NCH-1:0] hit;
    logic [NCH-1:0] wr_ok;
    logic [NCH-1:0] wr_en;
    logic           sel_ok;
    logic           err_q, err_d;

    // Decoding against each real channel keeps out-of-range sel from aliasing.
    always_comb begin
        hit = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SELW'(k)) hit[k] = 1'b1;
        end
    end

    assign sel_ok = |hit;

    always_comb begin
        in_ready = 1'b1;
        if (bcast) begin
            in_ready = &wr_ok;
        end else if (sel_ok) begin
            in_ready = |(hit & wr_ok);
        end
    end

    assign wr_en = {NCH{in_valid & in_ready}}
                 & (bcast ? {NCH{1'b1}} : hit);

    assign err_d = err_q | (in_valid & ~bcast & ~sel_ok);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_sel = err_q;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        demux_chan_reg #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk       (clk),
            .clr_n     (clr_n),
            .wr_i      (wr_en[g]),
            .data_i    (in_data),
            .pop_i     (out_ready[g]),
            .writable_o(wr_ok[g]),
            .valid_o   (out_valid[g]),
            .data_o    (out_data[g*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_bus_demux_reg.sv
// Bench for bus_demux_reg: an 8x8 build and a 16-bit 5-channel build
// checked against per-channel queue models plus directed literal checks.
module tb_bus_demux_reg;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  a_data;
    logic [2:0]  a_sel;
    logic        a_bc, a_iv, a_rdy, a_err;
    logic [63:0] a_odat;
    logic [7:0]  a_oval, a_ordy;

    logic [15:0] b_data;
    logic [2:0]  b_sel;
    logic        b_bc, b_iv, b_rdy, b_err;
    logic [79:0] b_odat;
    logic [4:0]  b_oval, b_ordy;

    bus_demux_reg #(.WIDTH(8), .NCH(8)) u_a (
        .clk(clk), .clr_n(clr_n), .in_data(a_data), .sel(a_sel),
        .bcast(a_bc), .in_valid(a_iv), .in_ready(a_rdy),
        .out_data(a_odat), .out_valid(a_oval), .out_ready(a_ordy),
        .err_sel(a_err)
    );

    bus_demux_reg #(.WIDTH(16), .NCH(5)) u_b (
        .clk(clk), .clr_n(clr_n), .in_data(b_data), .sel(b_sel),
        .bcast(b_bc), .in_valid(b_iv), .in_ready(b_rdy),
        .out_data(b_odat), .out_valid(b_oval), .out_ready(b_ordy),
        .err_sel(b_err)
    );

    int n_pass = 0;
    int n_tot  = 0;
    bit mon_en = 1'b0;

    // Model: each channel is a FIFO of undelivered words plus its last word.
    logic [15:0] mq[2][8][$];
    logic [15:0] mlast[2][8];
    bit          merr[2];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic bit m_ready(input int m, input int nch, input bit bc,
                                   input int s, input logic [7:0] ordy);
        bit ok;
        ok = 1'b1;
        if (bc) begin
            for (int k = 0; k < nch; k++)
                if (mq[m][k].size() != 0 && !ordy[k]) ok = 1'b0;
        end else if (s < nch) begin
            ok = (mq[m][s].size() == 0) || ordy[s];
        end
        return ok;
    endfunction

    task automatic m_step(input int m, input int nch, input bit bc,
                          input int s, input bit iv, input logic [15:0] d,
                          input logic [7:0] ordy);
        bit rdy;
        rdy = m_ready(m, nch, bc, s, ordy);
        for (int k = 0; k < nch; k++)
            if (ordy[k] && mq[m][k].size() != 0) void'(mq[m][k].pop_front());
        if (iv && rdy) begin
            if (bc) begin
                for (int k = 0; k < nch; k++) begin
                    mq[m][k].push_back(d);
                    mlast[m][k] <= d;
                end
            end else if (s < nch) begin
                mq[m][s].push_back(d);
                mlast[m][s] <= d;
            end else begin
                merr[m] <= 1'b1;
            end
        end
    endtask

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int m = 0; m < 2; m++) begin
                merr[m] <= 1'b0;
                for (int k = 0; k < 8; k++) begin
                    mq[m][k].delete();
                    mlast[m][k] <= '0;
                end
            end
        end else begin
            m_step(0, 8, a_bc, int'(a_sel), a_iv, {8'h00, a_data}, a_ordy);
            m_step(1, 5, b_bc, int'(b_sel), b_iv, b_data, {3'b000, b_ordy});
        end
    end

    task automatic mon_check();
        logic [7:0] ev;
        ev = '0;
        for (int k = 0; k < 8; k++) ev[k] = (mq[0][k].size() != 0);
        chk("a_in_ready", 64'(a_rdy),
            64'(m_ready(0, 8, a_bc, int'(a_sel), a_ordy)));
        chk("a_out_valid", 64'(a_oval), 64'(ev));
        chk("a_err_sel", 64'(a_err), 64'(merr[0]));
        for (int k = 0; k < 8; k++)
            chk($sformatf("a_out_data[%0d]", k),
                64'(a_odat[k*8 +: 8]), 64'(mlast[0][k][7:0]));
        ev = '0;
        for (int k = 0; k < 5; k++) ev[k] = (mq[1][k].size() != 0);
        chk("b_in_ready", 64'(b_rdy),
            64'(m_ready(1, 5, b_bc, int'(b_sel), {3'b000, b_ordy})));
        chk("b_out_valid", 64'(b_oval), 64'(ev[4:0]));
        chk("b_err_sel", 64'(b_err), 64'(merr[1]));
        for (int k = 0; k < 5; k++)
            chk($sformatf("b_out_data[%0d]", k),
                64'(b_odat[k*16 +: 16]), 64'(mlast[1][k]));
    endtask

    always @(negedge clk) begin
        if (mon_en && clr_n) mon_check();
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_data = '0; a_sel = '0; a_bc = 1'b0; a_iv = 1'b0; a_ordy = '0;
        b_data = '0; b_sel = '0; b_bc = 1'b0; b_iv = 1'b0; b_ordy = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_oval", 64'(a_oval), 64'h0);
        chk("rst_a_odat", a_odat, 64'h0);
        chk("rst_a_err", 64'(a_err), 64'h0);
        chk("rst_b_oval", 64'(b_oval), 64'h0);
        #2 clr_n = 1'b1;
        mon_en = 1'b1;

        cyc();
        @(negedge clk);
        chk("first_ready", 64'(a_rdy), 64'h1);

        cyc();
        a_sel = 3'd3; a_data = 8'hA5; a_iv = 1'b1;
        @(negedge clk);
        chk("route_rdy", 64'(a_rdy), 64'h1);
        cyc();
        a_iv = 1'b0;
        @(negedge clk);
        chk("route_oval", 64'(a_oval), 64'h08);
        chk("route_odat", a_odat, 64'h0000_0000_A500_0000);

        cyc();
        a_iv = 1'b1; a_data = 8'h5A; a_sel = 3'd3;
        @(negedge clk);
        chk("bp_rdy_low", 64'(a_rdy), 64'h0);
        cyc();
        a_ordy = 8'h08;
        @(negedge clk);
        chk("bp_rdy_pass", 64'(a_rdy), 64'h1);
        cyc();
        a_iv = 1'b0; a_ordy = '0;
        @(negedge clk);
        chk("bp_oval", 64'(a_oval), 64'h08);
        chk("bp_ch3", 64'(a_odat[31:24]), 64'h5A);

        cyc();
        a_iv = 1'b1; a_sel = 3'd6; a_data = 8'h66; a_ordy = 8'h08;
        cyc();
        a_sel = 3'd0; a_bc = 1'b1; a_data = 8'h3C; a_ordy = '0;
        @(negedge clk);
        chk("bc_rdy_low", 64'(a_rdy), 64'h0);
        cyc();
        a_ordy = 8'h40;
        @(negedge clk);
        chk("bc_rdy", 64'(a_rdy), 64'h1);
        cyc();
        a_iv = 1'b0; a_bc = 1'b0; a_ordy = '0;
        @(negedge clk);
        chk("bc_oval", 64'(a_oval), 64'hFF);
        chk("bc_odat", a_odat, 64'h3C3C_3C3C_3C3C_3C3C);
        cyc();
        a_ordy = 8'hFF;
        cyc();
        a_ordy = '0;

        b_sel = 3'd6; b_iv = 1'b1; b_data = 16'hBEEF;
        @(negedge clk);
        chk("ill_rdy", 64'(b_rdy), 64'h1);
        chk("ill_err_pre", 64'(b_err), 64'h0);
        cyc();
        b_iv = 1'b0;
        @(negedge clk);
        chk("ill_err", 64'(b_err), 64'h1);
        chk("ill_oval", 64'(b_oval), 64'h0);
        repeat (22) cyc();
        @(negedge clk);
        chk("ill_err_held", 64'(b_err), 64'h1);

        cyc();
        a_iv = 1'b1; a_sel = 3'd0; a_data = 8'h11;
        cyc();
        a_sel = 3'd2; a_data = 8'h22;
        cyc();
        a_sel = 3'd7; a_data = 8'h77;
        cyc();
        a_iv = 1'b0;
        @(negedge clk);
        chk("pre_rst_oval", 64'(a_oval), 64'h85);
        cyc();
        #1 clr_n = 1'b0;
        #1;
        chk("async_oval", 64'(a_oval), 64'h0);
        chk("async_odat", a_odat, 64'h0);
        chk("async_b_err", 64'(b_err), 64'h0);
        #1 clr_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", 64'(a_rdy), 64'h1);

        repeat (10000) begin
            cyc();
            a_sel  = 3'($urandom_range(0, 7));
            a_bc   = ($urandom_range(0, 7) == 0);
            a_iv   = ($urandom_range(0, 3) != 0);
            a_data = 8'($urandom);
            a_ordy = 8'($urandom);
            b_sel  = 3'($urandom_range(0, 5));
            b_bc   = ($urandom_range(0, 7) == 0);
            b_iv   = ($urandom_range(0, 3) != 0);
            b_data = 16'($urandom);
            b_ordy = 5'($urandom);
        end
        cyc();
        a_iv = 1'b0; b_iv = 1'b0;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
